// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_unit_pkg
// Brief   : Op codes and FSM states shared by the multiply/divide engine.
// Revision: 1.0
// ============================================================================
package muldiv_unit_pkg;

  localparam logic [1:0] c_op_mult  = 2'b00;
  localparam logic [1:0] c_op_multu = 2'b01;
  localparam logic [1:0] c_op_div   = 2'b10;
  localparam logic [1:0] c_op_divu  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_div_radix2.sv
`default_nettype none
// ============================================================================
// Module  : div_radix2
// Brief   : One restoring radix-2 divide step (shift, trial subtract, select).
// Revision: 1.0
// ============================================================================
module div_radix2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  // quo_in doubles as the dividend shift register; its MSB feeds the remainder
  assign w_rem_sh = {rem_in, quo_in[WIDTH-1]};
  assign w_diff   = w_rem_sh - {1'b0, divisor};
  assign w_ge     = ~w_diff[WIDTH];
  assign rem_out  = w_ge ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];
  assign quo_out  = {quo_in[WIDTH-2:0], w_ge};

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : muldiv_unit
// Brief   : Multi-cycle MULT/MULTU/DIV/DIVU engine with pipeline stall/done.
// Revision: 1.0
// ============================================================================
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2((WIDTH > MUL_LAT) ? WIDTH : MUL_LAT);
  localparam logic [CNT_W-1:0] c_mul_last = CNT_W'(MUL_LAT - 2);
  localparam logic [CNT_W-1:0] c_div_last = CNT_W'(WIDTH - 1);

  state_t             r_state, w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a, r_b, r_quo, r_rem, r_div, r_hi, r_lo;
  logic               r_signed;
  logic               w_accept, w_op_div, w_op_signed;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_quo_step, w_rem_step, w_quo_fix, w_rem_fix;
  logic [2*WIDTH-1:0] w_a_ext, w_b_ext, w_prod;

  assign w_op_div    = (op == c_op_div) || (op == c_op_divu);
  assign w_op_signed = (op == c_op_mult) || (op == c_op_div);
  assign w_abs_a     = (w_op_signed && src_a[WIDTH-1]) ? -src_a : src_a;
  assign w_abs_b     = (w_op_signed && src_b[WIDTH-1]) ? -src_b : src_b;

  // Extending to the full product width makes a plain multiply exact mod 2^(2W)
  assign w_a_ext = {{WIDTH{r_signed & r_a[WIDTH-1]}}, r_a};
  assign w_b_ext = {{WIDTH{r_signed & r_b[WIDTH-1]}}, r_b};
  assign w_prod  = w_a_ext * w_b_ext;

  div_radix2 #(.WIDTH(WIDTH)) u_div_step (
    .rem_in  (r_rem),
    .quo_in  (r_quo),
    .divisor (r_div),
    .rem_out (w_rem_step),
    .quo_out (w_quo_step)
  );

  always_comb begin
    w_quo_fix = r_quo;
    w_rem_fix = r_rem;
    if (r_b == '0) begin
      w_rem_fix = r_a;
      w_quo_fix = '1;
    end else if (r_signed) begin
      if (r_a[WIDTH-1] ^ r_b[WIDTH-1]) w_quo_fix = -r_quo;
      if (r_a[WIDTH-1])                w_rem_fix = -r_rem;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !flush) begin
          w_accept = 1'b1;
          w_next   = w_op_div ? ST_DIV : ST_MUL;
        end
      end
      ST_MUL:  if (r_cnt == c_mul_last) w_next = ST_DONE;
      ST_DIV:  if (r_cnt == c_div_last) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (flush) w_next = ST_IDLE;
    stall = rst & (w_accept | (r_state inside {ST_MUL, ST_DIV, ST_FIX}));
    done  = (r_state == ST_DONE) & ~flush;
    busy  = (r_state != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
      r_div    <= '0;
      r_signed <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_a      <= src_a;
            r_b      <= src_b;
            r_signed <= w_op_signed;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= w_abs_a;
            r_div    <= w_abs_b;
          end
        end
        ST_MUL: r_cnt <= r_cnt + 1'b1;
        ST_DIV: begin
          r_rem <= w_rem_step;
          r_quo <= w_quo_step;
          r_cnt <= r_cnt + 1'b1;
        end
        default: ;
      endcase
      // Results land only on DONE entry; a flush redirects w_next and blocks this
      if (w_next == ST_DONE)
        {r_hi, r_lo} <= (r_state == ST_FIX) ? {w_rem_fix, w_quo_fix} : w_prod;
    end
  end

  assign hi = r_hi;
  assign lo = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_muldiv_unit
// Brief   : Self-checking bench for muldiv_unit with a result scoreboard.
// Revision: 1.0
// ============================================================================
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  localparam int CYC_BUDGET = 60;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic        stall, done, busy;
  logic [31:0] hi, lo;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [63:0] sb[$];
  logic [31:0] last_hi = '0;
  logic [31:0] last_lo = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32), .MUL_LAT(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .flush (flush),
    .stall (stall),
    .done  (done),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb2;
    longint unsigned ua, ub;
    int              q, r;
    case (o)
      c_op_mult: begin sa = $signed(a); sb2 = $signed(b); return sa * sb2; end
      c_op_multu: begin ua = a; ub = b; return ua * ub; end
      c_op_div: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
        return {r, q};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] o);
    return (o == c_op_div || o == c_op_divu) ? 34 : 3;
  endfunction

  // Starts an op at the current cycle, holds start until done, reports timing
  task automatic drive_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int done_cyc, output int stall_cnt,
                          output logic [31:0] gh, output logic [31:0] gl);
    done_cyc = -1; stall_cnt = 0; gh = '0; gl = '0;
    sb.push_back(model(o, a, b));
    start = 1'b1; op = o; src_a = a; src_b = b;
    for (int k = 0; k < CYC_BUDGET; k++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (done) begin done_cyc = k; gh = hi; gl = lo; end
      @(posedge clk); #1;
      if (done_cyc >= 0) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b1; op = c_op_divu; src_a = 32'd5; src_b = 32'd1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", stall); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    logic [1:0]  ops [3] = '{c_op_mult, c_op_multu, c_op_mult};
    logic [31:0] as  [3] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h8000_0000};
    logic [31:0] bs  [3] = '{32'd3, 32'hFFFF_FFFF, 32'h8000_0000};
    int dc, sc; logic [31:0] gh, gl; logic [63:0] exp;
    for (int i = 0; i < 3; i++) begin
      drive_op(ops[i], as[i], bs[i], dc, sc, gh, gl);
      exp = sb.pop_front();
      n_checks++; if (dc !== 3) begin n_fail++; $display("FAIL mult%0d_done_cycle: got %0d want 3", i, dc); end
      n_checks++; if (sc !== 3) begin n_fail++; $display("FAIL mult%0d_stall_cycles: got %0d want 3", i, sc); end
      n_checks++; if (gh !== exp[63:32]) begin n_fail++; $display("FAIL mult%0d_hi: got %h want %h", i, gh, exp[63:32]); end
      n_checks++; if (gl !== exp[31:0]) begin n_fail++; $display("FAIL mult%0d_lo: got %h want %h", i, gl, exp[31:0]); end
      last_hi = exp[63:32]; last_lo = exp[31:0];
    end
  endtask

  task automatic test_div();
    logic [1:0]  ops [6] = '{c_op_div, c_op_divu, c_op_divu, c_op_div, c_op_div, c_op_divu};
    logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'd100, 32'd100, 32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFF};
    logic [31:0] bs  [6] = '{32'd2, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'd1};
    int dc, sc; logic [31:0] gh, gl; logic [63:0] exp;
    for (int i = 0; i < 6; i++) begin
      drive_op(ops[i], as[i], bs[i], dc, sc, gh, gl);
      exp = sb.pop_front();
      n_checks++; if (dc !== 34) begin n_fail++; $display("FAIL div%0d_done_cycle: got %0d want 34", i, dc); end
      n_checks++; if (sc !== 34) begin n_fail++; $display("FAIL div%0d_stall_cycles: got %0d want 34", i, sc); end
      n_checks++; if (gh !== exp[63:32]) begin n_fail++; $display("FAIL div%0d_hi: got %h want %h", i, gh, exp[63:32]); end
      n_checks++; if (gl !== exp[31:0]) begin n_fail++; $display("FAIL div%0d_lo: got %h want %h", i, gl, exp[31:0]); end
      last_hi = exp[63:32]; last_lo = exp[31:0];
    end
  endtask

  task automatic test_back_to_back();
    int dc, sc, want; logic [31:0] gh, gl, a, b; logic [1:0] o; logic [63:0] exp;
    for (int i = 0; i < 8; i++) begin
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      want = lat_of(o);
      drive_op(o, a, b, dc, sc, gh, gl);
      exp = sb.pop_front();
      n_checks++; if (dc !== want) begin n_fail++; $display("FAIL b2b%0d_done_cycle: got %0d want %0d", i, dc, want); end
      n_checks++; if ({gh, gl} !== exp) begin n_fail++; $display("FAIL b2b%0d_result op=%0d a=%h b=%h: got %h want %h", i, o, a, b, {gh, gl}, exp); end
      last_hi = exp[63:32]; last_lo = exp[31:0];
    end
  endtask

  task automatic test_flush();
    int dc, sc; logic [31:0] gh, gl; logic [63:0] exp; bit seen_done;
    seen_done = 0;
    start = 1'b1; op = c_op_divu; src_a = 32'd1000; src_b = 32'd7;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); if (done) seen_done = 1;
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(negedge clk); if (done) seen_done = 1;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk); if (done) seen_done = 1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_c11: got %b want 0", busy); end
    n_checks++; if (seen_done !== 1'b0) begin n_fail++; $display("FAIL flush_done_pulse: got %b want 0", seen_done); end
    n_checks++; if (hi !== last_hi) begin n_fail++; $display("FAIL flush_hi_kept: got %h want %h", hi, last_hi); end
    n_checks++; if (lo !== last_lo) begin n_fail++; $display("FAIL flush_lo_kept: got %h want %h", lo, last_lo); end
    @(posedge clk); #1;
    drive_op(c_op_mult, 32'd12345, 32'hFFFF_FF00, dc, sc, gh, gl);
    exp = sb.pop_front();
    n_checks++; if (dc !== 3) begin n_fail++; $display("FAIL flush_next_done_cycle: got %0d want 3", dc); end
    n_checks++; if ({gh, gl} !== exp) begin n_fail++; $display("FAIL flush_next_result: got %h want %h", {gh, gl}, exp); end
    last_hi = exp[63:32]; last_lo = exp[31:0];
  endtask

  task automatic test_flush_idle_done();
    start = 1'b1; flush = 1'b1; op = c_op_mult; src_a = 32'd5; src_b = 32'd6;
    @(negedge clk);
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_idle_stall: got %b want 0", stall); end
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_idle_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    start = 1'b1; src_a = 32'd7; src_b = 32'd9;
    repeat (3) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(negedge clk);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL flush_done_state_busy: got %b want 1", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_done_suppressed: got %b want 0", done); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL flush_done_stall: got %b want 0", stall); end
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_done_to_idle: got %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  task automatic test_rst_mid();
    start = 1'b1; op = c_op_div; src_a = 32'hFFFF_FFF9; src_b = 32'd2;
    repeat (5) begin @(posedge clk); #1; end
    rst = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rstmid_stall: got %b want 0", stall); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    n_checks++; if (hi !== 32'h0) begin n_fail++; $display("FAIL rstmid_hi: got %h want 0", hi); end
    n_checks++; if (lo !== 32'h0) begin n_fail++; $display("FAIL rstmid_lo: got %h want 0", lo); end
    @(posedge clk); #1;
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_release_busy: got %b want 0", busy); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_back_to_back();
    test_flush();
    test_flush_idle_done();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
